writeback: RTL and testbench
============================

Name: writeback

Overview:
- Final (WB) pipeline stage of the Dual-IS core.
- Selects the register-file write value from either the ALU result or the load data returned by the memory stage.
- Load data can be sign- or zero-extended to byte, half or word width; a link-address source (PC+4) is also supported.
- The selected value and its register-write control are registered once, then drive the register-file write port.

Parameters:
- DATA_W, 32, datapath width; must be 32 for sub-word extension rules below.
- REG_AW, 5, register-file address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- aluout  input  DATA_W  ALU result from MEM/WB.
- read_data  input  DATA_W  raw 32-bit word read from data memory.
- mem_to_reg  input  1  1 = select load data, 0 = select ALU result.
- link_sel  input  1  1 = select pc_plus4 (JAL/JALR); overrides mem_to_reg.
- pc_plus4  input  DATA_W  link address.
- mem_size  input  2  00 byte, 01 half, 10 word, 11 treated as word.
- mem_unsigned  input  1  1 = zero-extend sub-word load, 0 = sign-extend.
- byte_off  input  2  low address bits of the load.
- valid_in  input  1  instruction in MEM/WB is valid.
- reg_write_in  input  1  instruction writes a destination register.
- rd_in  input  REG_AW  destination register index.
- wb_data  output  DATA_W  registered write-back value.
- wb_we  output  1  registered register-file write enable.
- wb_rd  output  REG_AW  registered destination index.

Behaviour:
- Reset: while rst=1 (asynchronous, any time), wb_data=0, wb_we=0, wb_rd=0. After deassertion, the first update occurs on the next rising clk edge.
- Load alignment (combinational):
  - byte: select read_data[8*byte_off +: 8].
  - half: select read_data[31:16] if byte_off[1]=1, else read_data[15:0]; byte_off[0] is ignored.
  - word: read_data unmodified; byte_off ignored.
  - Sub-word result is extended to 32 bits by its MSB (mem_unsigned=0) or with zeros (mem_unsigned=1).
- Source select priority: link_sel=1 selects pc_plus4; else mem_to_reg=1 selects the aligned load value; else aluout.
- Latency: inputs sampled on a rising edge appear on wb_data/wb_we/wb_rd immediately after that edge. Outputs are held until the next edge. Exactly one cycle, no stall or backpressure.
- Write enable and index:
  - wb_we <= valid_in & reg_write_in & (rd_in != 0); register x0 is never written.
  - wb_rd <= rd_in whenever valid_in=1; otherwise it holds its prior value.
- wb_data is updated every edge regardless of valid_in, so bubble data is visible but wb_we=0 masks it.
- Input changes between edges have no effect on outputs until the next edge; no combinational input-to-output path.
- Simultaneous link_sel=1 and mem_to_reg=1: link wins.
- Reset asserted mid-stream clears outputs immediately; a pending value is discarded.

Test Plan:
- Common setup: link_sel=0, mem_size=10, valid_in=1, reg_write_in=1, rd_in=5.
- aluout=12345678, mem_to_reg=0, one edge -> wb_data=12345678, wb_we=1, wb_rd=5.
- read_data=87654321, mem_to_reg=1, one edge -> wb_data=87654321. Then aluout=AABBCCDD, mem_to_reg=0 -> AABBCCDD. Then read_data=DEADBEEF, mem_to_reg=1 -> DEADBEEF.
- read_data=DEADBEEF, mem_to_reg=1, mem_size=00, byte_off=3:
  - mem_unsigned=0 -> FFFFFFDE.
  - mem_unsigned=1 -> 000000DE.
  - mem_size=01, byte_off=0, mem_unsigned=0 -> FFFFBEEF.
- link_sel=1, mem_to_reg=1, pc_plus4=00000104 -> wb_data=00000104. Then rd_in=0 -> wb_we=0. Then valid_in=0 -> wb_we=0 and wb_rd holds.
- With outputs nonzero, assert rst between edges -> wb_data=0, wb_we=0, wb_rd=0 before the next edge, and they stay 0 while rst=1.

Source files
------------

// File: rtl/writeback.sv
// Final pipeline stage: selects the link address, the aligned and extended load data or the ALU result as the register-file write value.
// Latency: one cycle. Inputs sampled on a rising edge appear on wb_data/wb_we/wb_rd right after that edge.
// Backpressure: none. The stage never stalls and updates on every edge.
module writeback #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] aluout,
    input  logic [DATA_W-1:0] read_data,
    input  logic              mem_to_reg,
    input  logic              link_sel,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [1:0]        byte_off,
    input  logic              valid_in,
    input  logic              reg_write_in,
    input  logic [REG_AW-1:0] rd_in,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_rd
);

    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic [DATA_W-1:0] load_val;
    logic [DATA_W-1:0] wb_next;

    always_comb begin
        byte_sel = read_data[7:0];
        case (byte_off)
            2'd0: byte_sel = read_data[7:0];
            2'd1: byte_sel = read_data[15:8];
            2'd2: byte_sel = read_data[23:16];
            2'd3: byte_sel = read_data[31:24];
            default: byte_sel = read_data[7:0];
        endcase
        // Only the upper address bit picks the halfword; an odd offset is not realigned.
        half_sel = byte_off[1] ? read_data[31:16] : read_data[15:0];
    end

    always_comb begin
        load_val = read_data;
        case (mem_size)
            2'b00:   load_val = {{(DATA_W-8){~mem_unsigned & byte_sel[7]}}, byte_sel};
            2'b01:   load_val = {{(DATA_W-16){~mem_unsigned & half_sel[15]}}, half_sel};
            default: load_val = read_data;
        endcase
    end

    always_comb begin
        wb_next = aluout;
        if (link_sel)
            wb_next = pc_plus4;
        else if (mem_to_reg)
            wb_next = load_val;
    end

    // Bubble data is still captured; wb_we alone qualifies it, and x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data <= '0;
            wb_we   <= 1'b0;
            wb_rd   <= '0;
        end else begin
            wb_data <= wb_next;
            wb_we   <= valid_in & reg_write_in & (rd_in != '0);
            if (valid_in)
                wb_rd <= rd_in;
        end
    end

endmodule

// File: tb/tb_writeback.sv
// Bench for writeback: drives stimulus between edges, queues expected outputs, compares after each edge.
module tb_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] aluout, read_data, pc_plus4;
    logic        mem_to_reg, link_sel, mem_unsigned, valid_in, reg_write_in;
    logic [1:0]  mem_size, byte_off;
    logic [4:0]  rd_in;
    logic [31:0] wb_data;
    logic        wb_we;
    logic [4:0]  wb_rd;

    typedef struct packed {
        logic [31:0] data;
        logic        we;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   vectors = 0;
    int   errors  = 0;

    writeback #(.DATA_W(32), .REG_AW(5)) dut (
        .clk(clk), .rst(rst), .aluout(aluout), .read_data(read_data),
        .mem_to_reg(mem_to_reg), .link_sel(link_sel), .pc_plus4(pc_plus4),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .byte_off(byte_off),
        .valid_in(valid_in), .reg_write_in(reg_write_in), .rd_in(rd_in),
        .wb_data(wb_data), .wb_we(wb_we), .wb_rd(wb_rd)
    );

    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b1;
        aluout = 32'h1111_2222; read_data = 32'h3333_4444; pc_plus4 = 32'h0;
        mem_to_reg = 1'b0; link_sel = 1'b0; mem_size = 2'b10; mem_unsigned = 1'b0;
        byte_off = 2'd0; valid_in = 1'b1; reg_write_in = 1'b1; rd_in = 5'd5;
        @(posedge clk); #1;
        vectors++;
        if ({wb_data, wb_we, wb_rd} !== {32'h0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_state got data=%h we=%b rd=%0d want 0/0/0", wb_data, wb_we, wb_rd);
        end
        #3 rst = 1'b0;
        #1;
        vectors++;
        if ({wb_data, wb_we, wb_rd} !== {32'h0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_release got data=%h we=%b rd=%0d want 0/0/0", wb_data, wb_we, wb_rd);
        end
    endtask

    task automatic test_select;
        logic        m2r [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] alu [4] = '{32'h1234_5678, 32'h0, 32'hAABB_CCDD, 32'h0};
        logic [31:0] rdat[4] = '{32'h0, 32'h8765_4321, 32'h0, 32'hDEAD_BEEF};
        logic [31:0] want[4] = '{32'h1234_5678, 32'h8765_4321, 32'hAABB_CCDD, 32'hDEAD_BEEF};
        for (int i = 0; i < 4; i++) begin
            mem_to_reg = m2r[i]; aluout = alu[i]; read_data = rdat[i];
            mem_size = 2'b10; link_sel = 1'b0; valid_in = 1'b1; reg_write_in = 1'b1; rd_in = 5'd5;
            sb.push_back('{data: want[i], we: 1'b1, rd: 5'd5});
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if ({wb_data, wb_we, wb_rd} !== e) begin
                errors++;
                $display("FAIL select[%0d] got data=%h we=%b rd=%0d want data=%h we=%b rd=%0d",
                         i, wb_data, wb_we, wb_rd, e.data, e.we, e.rd);
            end
        end
    endtask

    task automatic test_extend;
        logic [31:0] rdat[11] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                  32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF,
                                  32'h1234_5678, 32'h1234_5678, 32'hDEAD_BEEF};
        logic [1:0]  size[11] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01, 2'b11,
                                  2'b01, 2'b00, 2'b10};
        logic [1:0]  off [11] = '{2'd3, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1,
                                  2'd0, 2'd0, 2'd2};
        logic        uns [11] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0,
                                  1'b0, 1'b0, 1'b1};
        logic [31:0] want[11] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_BEEF, 32'hFFFF_FFBE,
                                  32'h0000_00AD, 32'hFFFF_DEAD, 32'h0000_DEAD, 32'hDEAD_BEEF,
                                  32'h0000_5678, 32'h0000_0078, 32'hDEAD_BEEF};
        for (int i = 0; i < 11; i++) begin
            read_data = rdat[i]; mem_size = size[i]; byte_off = off[i]; mem_unsigned = uns[i];
            mem_to_reg = 1'b1; link_sel = 1'b0; aluout = 32'h5555_5555;
            sb.push_back('{data: want[i], we: 1'b1, rd: 5'd5});
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if ({wb_data, wb_we, wb_rd} !== e) begin
                errors++;
                $display("FAIL extend[%0d] got data=%h we=%b rd=%0d want data=%h we=%b rd=%0d",
                         i, wb_data, wb_we, wb_rd, e.data, e.we, e.rd);
            end
        end
        mem_size = 2'b10; byte_off = 2'd0; mem_unsigned = 1'b0;
    endtask

    task automatic test_link_and_enable;
        logic [4:0]  rd  [5] = '{5'd5, 5'd0, 5'd7, 5'd12, 5'd9};
        logic        vld [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        rw  [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] pc  [5] = '{32'h0000_0104, 32'h0000_0108, 32'h0000_010C, 32'h0000_0110, 32'h0000_0114};
        logic        we  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [4:0]  wrd [5] = '{5'd5, 5'd0, 5'd7, 5'd7, 5'd9};
        for (int i = 0; i < 5; i++) begin
            link_sel = 1'b1; mem_to_reg = 1'b1; read_data = 32'hDEAD_BEEF; aluout = 32'h5555_5555;
            pc_plus4 = pc[i]; rd_in = rd[i]; valid_in = vld[i]; reg_write_in = rw[i];
            sb.push_back('{data: pc[i], we: we[i], rd: wrd[i]});
            @(posedge clk); #1;
            e = sb.pop_front();
            vectors++;
            if ({wb_data, wb_we, wb_rd} !== e) begin
                errors++;
                $display("FAIL link_we[%0d] got data=%h we=%b rd=%0d want data=%h we=%b rd=%0d",
                         i, wb_data, wb_we, wb_rd, e.data, e.we, e.rd);
            end
        end
    endtask

    task automatic test_no_comb_path;
        link_sel = 1'b0; mem_to_reg = 1'b0; aluout = 32'hCAFE_F00D;
        valid_in = 1'b1; reg_write_in = 1'b1; rd_in = 5'd3;
        sb.push_back('{data: 32'hCAFE_F00D, we: 1'b1, rd: 5'd3});
        @(posedge clk); #1;
        aluout = 32'h0BAD_0BAD; rd_in = 5'd0; valid_in = 1'b0;
        #3;
        e = sb.pop_front();
        vectors++;
        if ({wb_data, wb_we, wb_rd} !== e) begin
            errors++;
            $display("FAIL hold_between_edges got data=%h we=%b rd=%0d want data=%h we=%b rd=%0d",
                     wb_data, wb_we, wb_rd, e.data, e.we, e.rd);
        end
    endtask

    task automatic test_mid_reset;
        valid_in = 1'b1; reg_write_in = 1'b1; rd_in = 5'd17; aluout = 32'h7777_8888;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        vectors++;
        if ({wb_data, wb_we, wb_rd} !== {32'h0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL mid_reset got data=%h we=%b rd=%0d want 0/0/0", wb_data, wb_we, wb_rd);
        end
        @(posedge clk); #1;
        vectors++;
        if ({wb_data, wb_we, wb_rd} !== {32'h0, 1'b0, 5'd0}) begin
            errors++;
            $display("FAIL reset_held got data=%h we=%b rd=%0d want 0/0/0", wb_data, wb_we, wb_rd);
        end
        #2 rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_select();
        test_extend();
        test_link_and_enable();
        test_no_comb_path();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
